// File: rtl/alu_sequencer.sv
// Issue-side ALU controller: latches one decoded operation, drives the combinational ALU,
// performs register-file writeback and owns SREG, including two-pass word and multiply ops.
`ifndef OPSEL_COUNT
`define OPSEL_COUNT 4
`endif

module alu_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic [1:0]                 issue_kind,
  input  logic [`OPSEL_COUNT-1:0]    issue_opsel,
  input  logic [ADDR_WIDTH-1:0]      issue_rd_addr,
  input  logic [ADDR_WIDTH-1:0]      issue_rr_addr,
  input  logic [DATA_WIDTH-1:0]      issue_imm,
  input  logic                       issue_use_imm,
  input  logic                       issue_cin_en,
  input  logic                       issue_cout_en,
  input  logic                       issue_wb_en,
  output logic [ADDR_WIDTH-1:0]      rf_rd_addr,
  output logic [ADDR_WIDTH-1:0]      rf_rr_addr,
  input  logic [DATA_WIDTH-1:0]      rf_rd_data,
  input  logic [DATA_WIDTH-1:0]      rf_rr_data,
  output logic                       rf_wr_en,
  output logic [ADDR_WIDTH-1:0]      rf_wr_addr,
  output logic [DATA_WIDTH-1:0]      rf_wr_data,
  output logic                       alu_enable,
  output logic [`OPSEL_COUNT-1:0]    alu_opsel,
  output logic [DATA_WIDTH-1:0]      alu_rd,
  output logic [DATA_WIDTH-1:0]      alu_rr,
  output logic [DATA_WIDTH-1:0]      alu_flags_in,
  output logic                       alu_cin_en,
  output logic                       alu_cout_en,
  input  logic [DATA_WIDTH-1:0]      alu_out,
  input  logic [2*DATA_WIDTH-1:0]    alu_mul_out,
  input  logic [DATA_WIDTH-1:0]      alu_flags_out,
  output logic [DATA_WIDTH-1:0]      sreg,
  output logic                       done
);

  localparam int unsigned FLAGS_C = 0;
  localparam int unsigned FLAGS_Z = 1;
  localparam int unsigned FLAGS_N = 2;
  localparam int unsigned FLAGS_V = 3;
  localparam int unsigned FLAGS_S = 4;

  localparam logic [1:0] KIND_WORD = 2'b01;
  localparam logic [1:0] KIND_MUL  = 2'b10;
  localparam logic [1:0] KIND_RSVD = 2'b11;

  typedef enum logic [2:0] {IDLE, EXEC, WLO, WHI, MLO, MHI} state_e;

  state_e                    state_q, state_d;
  logic [1:0]                kind_q;
  logic [`OPSEL_COUNT-1:0]   opsel_q;
  logic [ADDR_WIDTH-1:0]     rd_addr_q, rr_addr_q, rd_hi_addr;
  logic [DATA_WIDTH-1:0]     imm_q, sreg_q, sreg_d, tmp_flags_q, hi_q;
  logic                      use_imm_q, cin_q, cout_q, wb_q, z_lo_q;
  logic                      wr_en;
  logic [ADDR_WIDTH-1:0]     wr_addr;
  logic [DATA_WIDTH-1:0]     wr_data;

  assign rd_hi_addr = rd_addr_q + ADDR_WIDTH'(1);
  assign sreg       = sreg_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (issue_valid) begin
        case (issue_kind)
          KIND_WORD: state_d = WLO;
          KIND_MUL:  state_d = MLO;
          default:   state_d = EXEC;
        endcase
      end
      WLO:     state_d = WHI;
      MLO:     state_d = MHI;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    issue_ready  = 1'b0;
    done         = 1'b0;
    alu_enable   = 1'b0;
    alu_opsel    = opsel_q;
    alu_rd       = rf_rd_data;
    alu_rr       = use_imm_q ? imm_q : rf_rr_data;
    alu_flags_in = sreg_q;
    alu_cin_en   = 1'b0;
    alu_cout_en  = 1'b0;
    rf_rd_addr   = rd_addr_q;
    rf_rr_addr   = rr_addr_q;
    wr_en        = 1'b0;
    wr_addr      = rd_addr_q;
    wr_data      = alu_out;
    sreg_d       = sreg_q;
    case (state_q)
      IDLE: issue_ready = 1'b1;
      EXEC: begin
        done = 1'b1;
        if (kind_q != KIND_RSVD) begin
          alu_enable  = 1'b1;
          alu_cin_en  = cin_q;
          alu_cout_en = cout_q;
          wr_en       = wb_q;
          sreg_d      = alu_flags_out;
        end
      end
      WLO: begin
        alu_enable  = 1'b1;
        alu_rr      = imm_q;
        alu_cout_en = 1'b1;
        wr_en       = 1'b1;
      end
      WHI: begin
        // High byte: carry chains in through tmp_flags; Z spans both bytes, H/T/I preserved.
        alu_enable      = 1'b1;
        rf_rd_addr      = rd_hi_addr;
        alu_rr          = '0;
        alu_flags_in    = tmp_flags_q;
        alu_cin_en      = 1'b1;
        alu_cout_en     = 1'b1;
        wr_en           = 1'b1;
        wr_addr         = rd_hi_addr;
        sreg_d[FLAGS_C] = alu_flags_out[FLAGS_C];
        sreg_d[FLAGS_N] = alu_flags_out[FLAGS_N];
        sreg_d[FLAGS_V] = alu_flags_out[FLAGS_V];
        sreg_d[FLAGS_S] = alu_flags_out[FLAGS_S];
        sreg_d[FLAGS_Z] = z_lo_q & alu_flags_out[FLAGS_Z];
        done            = 1'b1;
      end
      MLO: begin
        alu_enable = 1'b1;
        wr_en      = 1'b1;
        wr_addr    = '0;
        wr_data    = alu_mul_out[DATA_WIDTH-1:0];
        sreg_d     = alu_flags_out;
      end
      MHI: begin
        wr_en   = 1'b1;
        wr_addr = ADDR_WIDTH'(1);
        wr_data = hi_q;
        done    = 1'b1;
      end
      default: ;
    endcase
    rf_wr_en   = wr_en;
    rf_wr_addr = wr_en ? wr_addr : '0;
    rf_wr_data = wr_en ? wr_data : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kind_q      <= '0;
      opsel_q     <= '0;
      rd_addr_q   <= '0;
      rr_addr_q   <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      cin_q       <= 1'b0;
      cout_q      <= 1'b0;
      wb_q        <= 1'b0;
      sreg_q      <= '0;
      tmp_flags_q <= '0;
      z_lo_q      <= 1'b0;
      hi_q        <= '0;
    end else begin
      sreg_q <= sreg_d;
      if (state_q == IDLE && issue_valid) begin
        kind_q    <= issue_kind;
        opsel_q   <= issue_opsel;
        rd_addr_q <= issue_rd_addr;
        rr_addr_q <= issue_rr_addr;
        imm_q     <= issue_imm;
        use_imm_q <= issue_use_imm;
        cin_q     <= issue_cin_en;
        cout_q    <= issue_cout_en;
        wb_q      <= issue_wb_en;
      end
      if (state_q == WLO) begin
        tmp_flags_q <= alu_flags_out;
        z_lo_q      <= alu_flags_out[FLAGS_Z];
      end
      if (state_q == MLO) hi_q <= alu_mul_out[2*DATA_WIDTH-1:DATA_WIDTH];
    end
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Issue-side controller for the 8-bit ALU. Accepts one operation at a time from the decoder and reads operands from the register file. Drives the ALU combinationally, then writes results back and owns the status register (SREG). Sequences the two multi-pass operation kinds: 16-bit word add/subtract (ADIW/SBIW, low byte then high byte with carry chaining) and multiply (R0 written first, then R1).

## Interface
Parameters:
- DATA_WIDTH, 8, datapath and SREG width
- ADDR_WIDTH, 5, register-file address width

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- issue_valid  in  1  decoder presents an operation
- issue_ready  out  1  high only in IDLE
- issue_kind  in  2  00 single-byte, 01 word, 10 multiply, 11 reserved
- issue_opsel  in  `OPSEL_COUNT  ALU operation select
- issue_rd_addr  in  ADDR_WIDTH  destination / first operand register
- issue_rr_addr  in  ADDR_WIDTH  second operand register
- issue_imm  in  DATA_WIDTH  immediate operand
- issue_use_imm  in  1  1: rr operand = issue_imm
- issue_cin_en, issue_cout_en  in  1 each  carry controls, single-byte kind only
- issue_wb_en  in  1  0: flags only, no write (CP/CPC)
- rf_rd_addr, rf_rr_addr  out  ADDR_WIDTH each  register-file read addresses
- rf_rd_data, rf_rr_data  in  DATA_WIDTH each  combinational read data
- rf_wr_en  out  1;  rf_wr_addr  out  ADDR_WIDTH;  rf_wr_data  out  DATA_WIDTH
- alu_enable  out  1;  alu_opsel  out  `OPSEL_COUNT;  alu_rd, alu_rr  out  DATA_WIDTH each
- alu_flags_in  out  DATA_WIDTH;  alu_cin_en, alu_cout_en  out  1 each
- alu_out  in  DATA_WIDTH;  alu_mul_out  in  2*DATA_WIDTH;  alu_flags_out  in  DATA_WIDTH
- sreg  out  DATA_WIDTH  status register, FLAGS_* bit layout
- done  out  1  one-cycle pulse in the final cycle of each operation

## Operation
- States: IDLE, EXEC, WLO, WHI, MLO, MHI.
- On reset, all registers clear:
  - state = IDLE; sreg = 0; done = 0; rf_wr_en = 0; alu_enable = 0; issue_ready = 1.
- Acceptance: issue_valid & issue_ready at a rising edge.
  - All issue_* fields latch.
  - Next state by kind: 00→EXEC, 01→WLO, 10→MLO, 11→EXEC with no write and no SREG update.
- EXEC:
  - Read rd and rr (or imm) and drive the ALU with the latched opsel and carry enables; alu_flags_in = sreg.
  - rf_wr_en = wb_en, writing alu_out to rd_addr; sreg ← alu_flags_out; done = 1; → IDLE.
- WLO (word, opsel must be ADD or SUB):
  - alu_rd = R[rd_addr], alu_rr = imm, cin_en = 0, cout_en = 1.
  - Write alu_out to rd_addr.
  - Latch alu_flags_out into tmp_flags and latch z_lo = FLAGS_Z; → WHI.
- WHI:
  - alu_rd = R[rd_addr+1] (address wraps modulo 2^ADDR_WIDTH), alu_rr = 0, alu_flags_in = tmp_flags, cin_en = 1, cout_en = 1.
  - Write alu_out to rd_addr+1.
  - SREG update: C, N, V, S from the ALU; Z = z_lo & alu Z; H, T and I keep their prior sreg values.
  - done = 1; → IDLE.
- MLO:
  - Drive the latched MUL/MULS/MULSU; write alu_mul_out[7:0] to R0.
  - Latch alu_mul_out[15:8] into hi_reg; sreg ← alu_flags_out; → MHI.
- MHI:
  - alu_enable = 0; write hi_reg to R1; done = 1; → IDLE.
- alu_enable = 1 in EXEC (kinds 00), WLO, WHI and MLO; 0 otherwise.
- Write ports are 0 whenever rf_wr_en = 0.

## Timing
- Accept at edge N.
- Single-byte: write and SREG update at edge N+1; done high during cycle N→N+1.
- Word and multiply: first write at N+1, second write at N+2; done high during cycle N+1→N+2.
- issue_ready is low for 1 cycle (single-byte) or 2 cycles (word, multiply).
- Back-to-back: a new operation may be accepted in the cycle immediately after done.
- A read of a register written by the previous operation sees the new value.
- Reset asserted mid-operation:
  - Immediate return to IDLE; no further writes; sreg = 0.
  - A low-byte write already committed at an earlier edge stays committed.
- issue_valid while issue_ready = 0 is ignored; the decoder holds its fields.

## Test plan
- Single ADD, R16 = 0x7F, R17 = 0x01, wb_en = 1 → R16 = 0x80 at N+1; sreg V = 1, N = 1, S = 0, Z = 0, C = 0; done for one cycle.
- CP (SUB, wb_en = 0), R16 = 0x05, R17 = 0x05 → no rf write; Z = 1.
- ADIW R25:R24 = 0x00FF, imm 0x01 → R24 = 0x00 at N+1, R25 = 0x01 at N+2; Z = 0, C = 0; H unchanged.
- SBIW R25:R24 = 0x0001, imm 0x01 → 0x0000; Z = 1.
- SBIW R25:R24 = 0x0000, imm 0x01 → 0xFFFF; C = 1, N = 1.
- MUL 0xFF × 0xFF → R0 = 0x01 at N+1, R1 = 0xFE at N+2; C = 1, Z = 0; issue_ready low for 2 cycles while issue_valid is held.
- Reset asserted in WHI of an ADIW → R25 not written; sreg = 0; issue_ready = 1 immediately. The next single ADD after reset release completes normally.
